// File: rtl/alsu_disp_pkg.sv
// Shared constants for the ALSU result display: segment codes,
// converter state encoding and BCD nibble width.
package alsu_disp_pkg;

    localparam int BCD_W = 4;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } bcd_state_e;

    function automatic logic [6:0] seg_of(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/alsu_seg_display_if.sv
// ALSU-to-display bundle: ALSU result/leds in, display drive out.
// master = ALSU/driver side, slave = display block.
interface alsu_seg_display_if;
    logic [5:0]  out_in;
    logic [15:0] leds_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        disp_valid;

    modport master (
        output out_in, leds_in,
        input  an, seg, dp, busy, disp_valid
    );

    modport slave (
        input  out_in, leds_in,
        output an, seg, dp, busy, disp_valid
    );
endinterface

// File: rtl/alsu_bin2bcd.sv
// Sequential double-dabble: 6-bit magnitude -> tens/ones BCD.
// Ports: clk, rst, start, mag[5:0] in; tens, ones, busy, done out.
module alsu_bin2bcd
    import alsu_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       mag,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             busy,
    output logic             done
);

    bcd_state_e  state;
    logic [2:0]  cnt;
    logic [13:0] sr;
    logic [13:0] adj;

    // Add-3 correction on each BCD nibble before the shift
    always_comb begin
        adj = sr;
        if (sr[13:10] >= 4'd5) adj[13:10] = sr[13:10] + 4'd3;
        if (sr[9:6]   >= 4'd5) adj[9:6]   = sr[9:6] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sr    <= 14'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr    <= {8'd0, mag};
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= adj << 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd5) begin
                        // done is high for exactly the UPDATE cycle
                        done  <= 1'b1;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tens = sr[13:10];
    assign ones = sr[9:6];

endmodule

// File: rtl/alsu_seg_display.sv
// 4-digit 7-segment display of the ALSU result with "Err" override.
// Ports: clk, rst (async high), bus (alsu_seg_display_if.slave).
// Build option ALSU_DISP_LZB_EN: leading-zero blanking of the tens digit.
module alsu_seg_display
    import alsu_disp_pkg::*;
#(
    parameter int SIGNED_IN   = 1,
    parameter int REFRESH_DIV = 50000
)
(
    input  logic               clk,
    input  logic               rst,
    alsu_seg_display_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [5:0]       last_val;
    logic             err_q;
    logic             shown_q;
    logic             sign_q;
    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] ones_q;
    logic             dv_q;

    logic             in_neg;
    logic [5:0]       mag;
    logic             start;
    logic [BCD_W-1:0] b_tens;
    logic [BCD_W-1:0] b_ones;
    logic             b_busy;
    logic             b_done;

    logic [CW-1:0]    rcnt;
    logic [1:0]       idx;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [6:0]       seg_nxt;

    assign in_neg = (SIGNED_IN != 0) && bus.out_in[5];
    // -32 wraps to 6'b100000, which reads as 32 unsigned
    assign mag    = in_neg ? (~bus.out_in + 6'd1) : bus.out_in;
    // Changes while busy are dropped; compare resumes once idle
    assign start  = !b_busy && (bus.out_in != last_val);

    alsu_bin2bcd u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mag   (mag),
        .tens  (b_tens),
        .ones  (b_ones),
        .busy  (b_busy),
        .done  (b_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val <= 6'd0;
            err_q    <= 1'b0;
            shown_q  <= 1'b0;
            sign_q   <= 1'b0;
            tens_q   <= '0;
            ones_q   <= '0;
            dv_q     <= 1'b0;
        end else begin
            err_q <= |bus.leds_in;
            dv_q  <= b_done;
            if (start) last_val <= bus.out_in;
            if (b_done) begin
                // last_val is frozen for the whole conversion
                shown_q <= 1'b1;
                sign_q  <= (SIGNED_IN != 0) && last_val[5];
                tens_q  <= b_tens;
                ones_q  <= b_ones;
            end
        end
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        if (err_q) begin
            case (idx)
                2'd3:    seg_nxt = SEG_E;
                2'd2:    seg_nxt = SEG_R;
                2'd1:    seg_nxt = SEG_R;
                default: seg_nxt = SEG_BLANK;
            endcase
        end else if (shown_q) begin
            case (idx)
                2'd0: seg_nxt = seg_of(ones_q);
`ifdef ALSU_DISP_LZB_EN
                2'd1: begin
                    if (tens_q != '0)
                        seg_nxt = seg_of(tens_q);
                    else
                        seg_nxt = sign_q ? SEG_MINUS : SEG_BLANK;
                end
                2'd2: seg_nxt = (sign_q && tens_q != '0) ? SEG_MINUS : SEG_BLANK;
`else
                2'd1: seg_nxt = seg_of(tens_q);
                2'd2: seg_nxt = sign_q ? SEG_MINUS : SEG_BLANK;
`endif
                default: seg_nxt = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt  <= '0;
            idx   <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            if (rcnt == CW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            an_q  <= ~(4'b0001 << idx);
            seg_q <= seg_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.busy       = b_busy;
    assign bus.disp_valid = dv_q;

endmodule

// File: tb/tb_alsu_seg_display.sv
// Directed bench for alsu_seg_display: reset, conversion timing,
// scan order, signed/unsigned values, Err override, abort by reset.
module tb_alsu_seg_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] EE = 7'b0000110;
    localparam logic [6:0] RR = 7'b0101111;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alsu_seg_display_if if1 ();
    alsu_seg_display_if if0 ();

    alsu_seg_display #(.SIGNED_IN(1), .REFRESH_DIV(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    alsu_seg_display #(.SIGNED_IN(0), .REFRESH_DIV(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    int   tests = 0;
    int   fails = 0;
    int   dv_cnt = 0;
    int   dv0;
    int   k;
    int   nb;
    int   dv_at;
    int   run;
    logic sel = 1'b0;
    logic [3:0] a_prev;

    logic [3:0] an_m;
    logic [6:0] seg_m;
    logic       busy_m;
    logic       dv_m;
    assign an_m   = sel ? if0.an         : if1.an;
    assign seg_m  = sel ? if0.seg        : if1.seg;
    assign busy_m = sel ? if0.busy       : if1.busy;
    assign dv_m   = sel ? if0.disp_valid : if1.disp_valid;

    always @(negedge clk) if (if1.disp_valid) dv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dv(input string tag, output int kk);
        kk = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dv_m) begin
                kk = i;
                break;
            end
        end
        chk({tag, "_dv_seen"}, (kk != 0), 1);
    endtask

    task automatic chk_scan(input string tag, input logic [6:0] e3,
                            input logic [6:0] e2, input logic [6:0] e1,
                            input logic [6:0] e0);
        logic [6:0] d0, d1, d2, d3;
        d0 = 7'h00; d1 = 7'h00; d2 = 7'h00; d3 = 7'h00;
        repeat (16) begin
            @(negedge clk);
            case (an_m)
                4'b1110: d0 = seg_m;
                4'b1101: d1 = seg_m;
                4'b1011: d2 = seg_m;
                4'b0111: d3 = seg_m;
                default: ;
            endcase
        end
        chk({tag, "_an3"}, d3, e3);
        chk({tag, "_an2"}, d2, e2);
        chk({tag, "_an1"}, d1, e1);
        chk({tag, "_an0"}, d0, e0);
    endtask

    function automatic logic [6:0] err_exp(input logic [3:0] a);
        case (a)
            4'b0111: return EE;
            4'b1011: return RR;
            4'b1101: return RR;
            default: return BL;
        endcase
    endfunction

    function automatic logic [6:0] num23(input logic [3:0] a);
        case (a)
            4'b1110: return S3;
            4'b1101: return S2;
            default: return BL;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        if1.out_in = 6'd0; if1.leds_in = 16'd0;
        if0.out_in = 6'd0; if0.leds_in = 16'd0;
        cyc(2);
        chk("rst_an",   if1.an, 4'b1111);
        chk("rst_seg",  if1.seg, BL);
        chk("rst_dp",   if1.dp, 1'b1);
        chk("rst_busy", if1.busy, 1'b0);
        chk("rst_dv",   if1.disp_valid, 1'b0);
        rst = 1'b0;
        cyc(2);
        chk_scan("blank0", BL, BL, BL, BL);
        chk("blank0_busy", if1.busy, 1'b0);

        // +23: busy 7 cycles, disp_valid on the 8th
        if1.out_in = 6'd23;
        nb = 0; dv_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (if1.busy) nb++;
            if (if1.disp_valid && dv_at == 0) dv_at = i;
        end
        chk("p23_busy_cycles", nb, 7);
        chk("p23_dv_cycle", dv_at, 8);
        chk_scan("p23", BL, BL, S2, S3);

        // Dwell of 4 cycles per digit and rotation incl. wrap
        @(negedge clk);
        a_prev = an_m;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (an_m != a_prev) break;
        end
        for (int t = 0; t < 5; t++) begin
            a_prev = an_m;
            run = 0;
            do begin
                @(negedge clk);
                run++;
            end while (an_m == a_prev && run < 10);
            chk("dwell", run, 4);
            chk("rotate", an_m, {a_prev[2:0], a_prev[3]});
        end

        // Err override and recovery without a disp_valid
        dv0 = dv_cnt;
        if1.leds_in = 16'hFFFF;
        cyc(2);
        chk("err_2nd_edge", seg_m, err_exp(an_m));
        chk_scan("err", EE, RR, RR, BL);
        if1.leds_in = 16'h0000;
        cyc(2);
        chk("err_clear", seg_m, num23(an_m));
        chk_scan("p23b", BL, BL, S2, S3);
        chk("err_no_dv", dv_cnt, dv0);

        // -5
        if1.out_in = 6'b111011;
        wait_dv("n5", k);
        cyc(2);
`ifdef ALSU_DISP_LZB_EN
        chk_scan("n5", BL, BL, MN, S5);
`else
        chk_scan("n5", BL, MN, S0, S5);
`endif

        // -32
        if1.out_in = 6'b100000;
        wait_dv("n32", k);
        cyc(2);
        chk_scan("n32", BL, MN, S3, S2);

        // Unsigned instance, 63
        sel = 1'b1;
        if0.out_in = 6'd63;
        wait_dv("u63", k);
        cyc(2);
        chk_scan("u63", BL, BL, S6, S3);
        sel = 1'b0;

        // Change during conversion: 23 then 9
        if1.out_in = 6'd23;
        cyc(2);
        if1.out_in = 6'd9;
        wait_dv("chg1", k);
        chk("chg1_tens", dut1.tens_q, 4'd2);
        chk("chg1_ones", dut1.ones_q, 4'd3);
        chk("chg1_busy_low", if1.busy, 1'b0);
        @(negedge clk);
        chk("chg2_start", if1.busy, 1'b1);
        wait_dv("chg2", k);
        chk("chg2_latency", k, 7);
        cyc(2);
`ifdef ALSU_DISP_LZB_EN
        chk_scan("chg09", BL, BL, BL, S9);
`else
        chk_scan("chg09", BL, BL, S0, S9);
`endif
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (if1.busy) nb++;
        end
        chk("no_requeue", nb, 0);

        // Async reset in the middle of SHIFT
        if1.out_in = 6'd17;
        cyc(3);
        chk("abort_busy_pre", if1.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_an",   if1.an, 4'b1111);
        chk("abort_seg",  if1.seg, BL);
        chk("abort_busy", if1.busy, 1'b0);
        chk("abort_dv",   if1.disp_valid, 1'b0);
        if1.out_in = 6'd0;
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        chk_scan("post_rst", BL, BL, BL, BL);
        chk("post_rst_busy", if1.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alsu_seg_display.md
Name: alsu_seg_display

Overview:
- Downstream consumer of the ALSU. Takes the registered 6-bit result `out` and the 16-bit `leds` bus and drives a 4-digit multiplexed 7-segment display on the board.
- A sequential double-dabble converter turns each new result into sign/tens/ones digits.
- A refresh scanner time-multiplexes the digits.
- A nonzero `leds` (ALSU invalid-opcode indication) forces the display to show "Err".

Parameters:
- SIGNED_IN, 1: 1 = treat out_in as 6-bit two's complement (-32..31); 0 = unsigned (0..63).
- REFRESH_DIV, 50000: clk cycles each digit stays lit; must be >= 2; benches override to 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- out_in  in  6  ALSU `out`.
- leds_in  in  16  ALSU `leds`.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; tied off at 1 after reset.
- busy  out  1  high while a conversion is in progress.
- disp_valid  out  1  one-cycle pulse when the digit registers update.

Behaviour:
- Reset is asynchronous on rst=1 and overrides everything. Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1, busy=0, disp_valid=0.
  - FSM in IDLE; last_val=0; digit registers = blank; scan index=0; refresh counter=0.
- err_q is a register: err_q <= (leds_in != 0) every cycle, giving one cycle of latency. It does not wait for the conversion FSM.
- Converter FSM:
  - IDLE
    - If out_in != last_val:
      - capture out_in into last_val;
      - compute the sign (out_in[5] & SIGNED_IN);
      - compute the magnitude as a 6-bit unsigned value; -32 gives 32;
      - go to SHIFT; busy=1.
    - Otherwise stay in IDLE.
  - SHIFT: 6 cycles. Each cycle: add 3 to any BCD nibble >= 5, then shift left one bit. A 3-bit counter runs 0..5.
  - UPDATE: 1 cycle. Load sign/tens/ones into the digit registers, pulse disp_valid=1, set busy=0 on exit, return to IDLE.
- Latency: disp_valid is high in the 8th cycle after the capture edge (1 capture + 6 shift + 1 update).
- out_in changes while busy are ignored. On return to IDLE the comparison against last_val re-triggers a conversion if the value differs. No value is queued.
- Reset during SHIFT or UPDATE aborts the conversion; the display returns to blank.
- Because last_val resets to 0, a post-reset out_in of 0 triggers no conversion and the display stays blank.
- Refresh scanner:
  - The counter counts 0..REFRESH_DIV-1. On wrap, the scan index advances 0→1→2→3→0.
  - an is the one-hot-low decode of the index: index 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
  - an and seg are registered and change together.
- Digit content when err_q=0:
  - an[0]: ones digit.
  - an[1]: tens digit.
  - an[2]: '-' if the value is negative, else blank.
  - an[3]: blank.
  - The tens digit shows '0' when zero, unless LZB_EN is defined.
- Digit content when err_q=1: an[3]='E', an[2]='r', an[1]='r', an[0]=blank. The digit registers are preserved, and the number reappears the cycle after err_q falls.
- Before the first UPDATE after reset, all digits are blank.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, 'E'=0000110, 'r'=0101111, blank=1111111

Optional Feature:
- Macro: ALSU_DISP_LZB_EN.
- Defined: leading-zero blanking. The tens digit is blank when tens==0.
  - For a negative value the '-' moves to an[1], and an[2] is blank.
  - Example: -5 shows "  -5".
- Undefined: the tens digit always displays; -5 shows " -05".

Decomposition:
- Package alsu_disp_pkg holds:
  - the segment code localparams (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_R, SEG_BLANK);
  - the FSM state encoding (IDLE, SHIFT, UPDATE);
  - the BCD nibble width constant.
- Sub-module alsu_bin2bcd: the IDLE/SHIFT/UPDATE double-dabble FSM. Interface: start, mag[5:0] in; tens[3:0], ones[3:0], busy, done out.
- The top level keeps the capture/compare logic, err_q, the refresh scanner and the segment muxing.

Test Plan:
- Reset: hold rst=1 → an=1111, seg=1111111, dp=1, busy=0. Assert rst again mid-scan → the same values immediately, without waiting for a clock edge.
- Positive value: SIGNED_IN=1, REFRESH_DIV=4, out_in=23, leds_in=0 →
  - busy=1 for 7 cycles, disp_valid pulses on the 8th cycle;
  - scan shows an=1110/seg=0110000 ('3'), 1101/0100100 ('2'), 1011/blank, 0111/blank;
  - each digit lasts 4 cycles, and the scan wraps.
- Negative value: out_in=6'b111011 (-5) →
  - without the macro: an[2]='-', an[1]='0', an[0]='5';
  - with ALSU_DISP_LZB_EN: an[1]='-', an[2] blank.
  - Also check -32 gives '-','3','2', and SIGNED_IN=0 with 63 gives '6','3'.
- Error: leds_in=16'hFFFF → from the 2nd edge: an[3..1]='E','r','r', an[0] blank. Set leds_in=0 → the prior number returns one cycle later, with no disp_valid pulse.
- Change during conversion: out_in=23, then 9 two cycles later → the first disp_valid shows 23; a second conversion starts in the cycle after UPDATE and shows 09. Setting rst=1 during SHIFT → blank display, busy=0.
